irq_nest_ctrl: RTL and testbench
================================

IRQ_NEST_CTRL -- requirements
Module: irq_nest_ctrl

Interface
REQ-001 SHALL have parameter NrIrqLines, default 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines).
REQ-002 SHALL have parameter NrIrqPrios, default 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios).
REQ-003 SHALL have parameter StackDepth, default 4, maximum nesting depth (>=1).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cand_valid_i  in  1  arbitrated candidate present (from interrupt controller).
REQ-007 cand_id_i  in  IrqWidth  candidate line index.
REQ-008 cand_level_i  in  PrioWidth  candidate priority.
REQ-009 cand_nest_i  in  1  candidate handler may itself be preempted.
REQ-010 cand_heti_i  in  1  candidate is hardware-extended (passed through).
REQ-011 irq_o / irq_id_o / irq_heti_o  out  1 / IrqWidth / 1  interrupt offered to core.
REQ-012 irq_ack_i  in  1  core takes the offered interrupt.
REQ-013 irq_exit_i  in  1  core returns from current handler (mret).
REQ-014 claim_o / claim_id_o  out  1 / IrqWidth  one-cycle claim to controller (clears pending).
REQ-015 level_o  out  PrioWidth  current running level (top of stack, 0 if empty).
REQ-016 depth_o  out  $clog2(StackDepth+1)  current nesting depth.
REQ-017 err_o  out  1  sticky: irq_exit_i received with empty stack.

Function
REQ-018 Eligibility: empty stack -> cand_level_i > 0; non-empty -> not full, top.nest = 1, and cand_level_i > top.level.
REQ-019 FSM states IDLE, OFFER, CLAIM; reset state IDLE.
REQ-020 IDLE: cand_valid_i & eligible -> latch id/level/nest/heti, go OFFER; else stay.
REQ-021 OFFER: irq_o = 1, irq_id_o/irq_heti_o from latch; irq_ack_i -> CLAIM.
REQ-022 OFFER without ack: if cand_valid_i = 0, or cand_level_i > latched level, or latch no longer eligible -> IDLE (offer withdrawn, one-cycle bubble).
REQ-023 OFFER: ack and withdraw condition in same cycle -> ack wins, go CLAIM.
REQ-024 CLAIM: claim_o = 1 for exactly one cycle with claim_id_o = latched id; push {level, nest} onto stack; go IDLE.
REQ-025 irq_o = 0 in IDLE and CLAIM; offer latency from eligible candidate to irq_o = 1 cycle.
REQ-026 irq_exit_i pops top entry in any state, effective next edge; level_o/depth_o update one cycle later.
REQ-027 Pop on empty stack: no state change, err_o set until reset.
REQ-028 Push and pop same cycle: pop then push; depth unchanged, top = new entry.
REQ-029 Overflow impossible by REQ-018; push when full SHALL not occur.

Reset
REQ-030 Reset: FSM IDLE, stack empty, latch zero; irq_o, irq_id_o, irq_heti_o, claim_o, claim_id_o, level_o, depth_o, err_o all 0.
REQ-031 Reset asserted mid-OFFER or mid-CLAIM aborts immediately; no claim_o emitted.

Configuration
REQ-032 Macro IRQ_NEST_WATERMARK_EN defined: extra output depth_max_o (width as depth_o), highest depth since reset, saturating.
REQ-033 Macro undefined: depth_max_o port and its register absent; all other behaviour identical.

Structure
REQ-034 Package hetic_pkg SHALL hold nest_entry_t {level, nest} and the FSM state enum.
REQ-035 Sub-module nest_stack (push/pop/top/depth/full/empty, StackDepth entries) SHALL hold the level stack; FSM in irq_nest_ctrl.

Verification
REQ-036 Empty stack, cand id 5 level 3 nest 1 -> irq_o next cycle id 5; ack -> claim_o id 5 one cycle, level_o = 3, depth_o = 1.
REQ-037 Running level 3 nest 1, cand id 9 level 2 -> no irq_o; cand level 7 -> offered, after ack level_o = 7, depth_o = 2.
REQ-038 Running level 3 nest 0, cand level 31 -> never offered; after irq_exit_i, level_o = 0, then level 31 offered.
REQ-039 In OFFER of id 5 level 3, cand changes to id 8 level 6 -> offer withdrawn, re-offered as id 8; ack and withdraw same cycle -> id 5 claimed.
REQ-040 StackDepth = 4 full with nest 1 entries, higher cand -> not offered; irq_exit_i on empty -> err_o = 1 until reset.
REQ-041 Claim and irq_exit_i same cycle at depth 2 -> depth_o stays 2, level_o = new level; reset asserted during OFFER -> all outputs 0, no claim_o.

Source files
------------

// File: rtl/hetic_pkg.sv
// Shared types for the nested-interrupt controller: stack entry layout, FSM states
// and the eligibility rule that decides whether a candidate may preempt.
package hetic_pkg;

  // Widest priority field a stack entry can carry (NrIrqPrios up to 256).
  localparam int unsigned PrioWidthMax = 8;

  typedef struct packed {
    logic [PrioWidthMax-1:0] level;
    logic                    nest;
  } nest_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_CLAIM = 2'd2
  } state_e;

  // Idle core accepts any non-zero level; a running handler is preempted only if it
  // allows nesting, there is room to save it, and the newcomer is strictly higher.
  function automatic logic is_eligible(input logic [PrioWidthMax-1:0] lvl,
                                       input nest_entry_t             top,
                                       input logic                    empty,
                                       input logic                    full);
    if (empty) return (lvl != '0);
    return !full && top.nest && (lvl > top.level);
  endfunction

endpackage

// File: rtl/irq_nest_ctrl_if.sv
// Candidate / core-handshake / claim bundle between interrupt controller, nesting
// controller and core. slave = nesting controller side, master = environment side.
interface irq_nest_ctrl_if #(
  parameter int unsigned NrIrqLines = 64,
  parameter int unsigned NrIrqPrios = 32,
  parameter int unsigned StackDepth = 4
);
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1);

  logic                  cand_valid_i;
  logic [IrqWidth-1:0]   cand_id_i;
  logic [PrioWidth-1:0]  cand_level_i;
  logic                  cand_nest_i;
  logic                  cand_heti_i;
  logic                  irq_o;
  logic [IrqWidth-1:0]   irq_id_o;
  logic                  irq_heti_o;
  logic                  irq_ack_i;
  logic                  irq_exit_i;
  logic                  claim_o;
  logic [IrqWidth-1:0]   claim_id_o;
  logic [PrioWidth-1:0]  level_o;
  logic [DepthWidth-1:0] depth_o;
  logic                  err_o;

  modport slave (
    input  cand_valid_i, cand_id_i, cand_level_i, cand_nest_i, cand_heti_i,
    input  irq_ack_i, irq_exit_i,
    output irq_o, irq_id_o, irq_heti_o, claim_o, claim_id_o, level_o, depth_o, err_o
  );

  modport master (
    output cand_valid_i, cand_id_i, cand_level_i, cand_nest_i, cand_heti_i,
    output irq_ack_i, irq_exit_i,
    input  irq_o, irq_id_o, irq_heti_o, claim_o, claim_id_o, level_o, depth_o, err_o
  );
endinterface

// File: rtl/nest_stack.sv
// LIFO of preempted handler contexts {level, nest}. A pop and a push in the same
// cycle replace the top entry; a pop on an empty stack is ignored.
module nest_stack
  import hetic_pkg::*;
#(
  parameter int unsigned Depth      = 4,
  parameter int unsigned DepthWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  nest_entry_t           entry_i,
  output nest_entry_t           top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  nest_entry_t           r_mem [Depth];
  logic [DepthWidth-1:0] r_depth;
  logic                  w_pop;
  logic                  w_push;
  logic [AddrWidth-1:0]  w_top_idx;
  logic [AddrWidth-1:0]  w_push_idx;

  assign empty_o    = (r_depth == '0);
  assign full_o     = (r_depth == DepthWidth'(Depth));
  assign w_pop      = pop_i & ~empty_o;
  assign w_push     = push_i & (w_pop | ~full_o);
  assign w_top_idx  = AddrWidth'(r_depth - DepthWidth'(1));
  assign w_push_idx = AddrWidth'(r_depth);
  assign top_o      = r_mem[w_top_idx];
  assign depth_o    = r_depth;

  // NOTE: storage needs no reset; an entry is only ever read below the depth pointer,
  // and the pointer itself is reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_pop ? w_top_idx : w_push_idx] <= entry_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth <= '0;
    end else if (w_push && !w_pop) begin
      r_depth <= r_depth + DepthWidth'(1);
    end else if (w_pop && !w_push) begin
      r_depth <= r_depth - DepthWidth'(1);
    end
  end

endmodule

// File: rtl/irq_nest_ctrl.sv
// Nested-interrupt controller: offers the arbitrated candidate to the core when it may
// preempt the running handler, claims it on ack and tracks the nesting stack.
// Optional IRQ_NEST_WATERMARK_EN adds depth_max_o (highest depth seen since reset).
module irq_nest_ctrl
  import hetic_pkg::*;
#(
  parameter int unsigned NrIrqLines = 64,
  parameter int unsigned NrIrqPrios = 32,
  parameter int unsigned StackDepth = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  irq_nest_ctrl_if.slave bus
`ifdef IRQ_NEST_WATERMARK_EN
  ,
  output logic [$clog2(StackDepth+1)-1:0] depth_max_o
`endif
);
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IrqWidth-1:0]   r_lat_id;
  logic [PrioWidth-1:0]  r_lat_level;
  logic                  r_lat_nest;
  logic                  r_lat_heti;
  logic                  r_err;
  logic                  w_latch_en;
  logic                  w_push;
  logic                  w_elig_cand;
  logic                  w_elig_lat;
  logic                  w_withdraw;
  nest_entry_t           w_push_entry;
  nest_entry_t           w_top;
  logic [DepthWidth-1:0] w_depth;
  logic                  w_full;
  logic                  w_empty;

  assign w_elig_cand = is_eligible(PrioWidthMax'(bus.cand_level_i), w_top, w_empty, w_full);
  assign w_elig_lat  = is_eligible(PrioWidthMax'(r_lat_level), w_top, w_empty, w_full);
  assign w_withdraw  = !bus.cand_valid_i || (bus.cand_level_i > r_lat_level) || !w_elig_lat;

  assign w_push_entry.level = PrioWidthMax'(r_lat_level);
  assign w_push_entry.nest  = r_lat_nest;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_latch_en     = 1'b0;
    w_push         = 1'b0;
    bus.irq_o      = 1'b0;
    bus.irq_id_o   = '0;
    bus.irq_heti_o = 1'b0;
    bus.claim_o    = 1'b0;
    bus.claim_id_o = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cand_valid_i && w_elig_cand) begin
          w_latch_en  = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        bus.irq_o      = 1'b1;
        bus.irq_id_o   = r_lat_id;
        bus.irq_heti_o = r_lat_heti;
        // The core's ack is final even if the candidate moved on in the same cycle.
        if (bus.irq_ack_i)  w_state_nxt = ST_CLAIM;
        else if (w_withdraw) w_state_nxt = ST_IDLE;
      end
      ST_CLAIM: begin
        bus.claim_o    = 1'b1;
        bus.claim_id_o = r_lat_id;
        w_push         = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lat_id    <= '0;
      r_lat_level <= '0;
      r_lat_nest  <= 1'b0;
      r_lat_heti  <= 1'b0;
    end else if (w_latch_en) begin
      r_lat_id    <= bus.cand_id_i;
      r_lat_level <= bus.cand_level_i;
      r_lat_nest  <= bus.cand_nest_i;
      r_lat_heti  <= bus.cand_heti_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else if (bus.irq_exit_i && w_empty) r_err <= 1'b1;
  end

  nest_stack #(
    .Depth      (StackDepth),
    .DepthWidth (DepthWidth)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (bus.irq_exit_i),
    .entry_i (w_push_entry),
    .top_o   (w_top),
    .depth_o (w_depth),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.level_o = w_empty ? '0 : PrioWidth'(w_top.level);
  assign bus.depth_o = w_depth;
  assign bus.err_o   = r_err;

`ifdef IRQ_NEST_WATERMARK_EN
  logic [DepthWidth-1:0] r_depth_max;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_depth_max <= '0;
    else if (w_depth > r_depth_max) r_depth_max <= w_depth;
  end

  assign depth_max_o = r_depth_max;
`endif

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed scenarios plus randomized traffic checked against a queue-based model
// of the nesting rules.
module tb_irq_nest_ctrl;
  localparam int Lines = 64;
  localparam int Prios = 32;
  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  irq_nest_ctrl_if #(.NrIrqLines(Lines), .NrIrqPrios(Prios), .StackDepth(Depth)) bus ();

`ifdef IRQ_NEST_WATERMARK_EN
  logic [2:0] depth_max;
  irq_nest_ctrl #(.NrIrqLines(Lines), .NrIrqPrios(Prios), .StackDepth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave), .depth_max_o(depth_max));
`else
  irq_nest_ctrl #(.NrIrqLines(Lines), .NrIrqPrios(Prios), .StackDepth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {int level; bit nest;} ment_t;
  ment_t stk[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int id, int lvl, bit nest, bit heti, bit ack, bit ex);
    bus.cand_valid_i = v;
    bus.cand_id_i    = 6'(id);
    bus.cand_level_i = 5'(lvl);
    bus.cand_nest_i  = nest;
    bus.cand_heti_i  = heti;
    bus.irq_ack_i    = ack;
    bus.irq_exit_i   = ex;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  // Offer, ack and claim a candidate; the caller guarantees it is eligible.
  task automatic take_irq(int id, int lvl, bit nest);
    drive(1, id, lvl, nest, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic pop_once();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #2;
    n_tests++;
    if ({bus.irq_o, bus.irq_id_o, bus.irq_heti_o, bus.claim_o, bus.claim_id_o,
         bus.level_o, bus.depth_o, bus.err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b id=%0d claim=%b level=%0d depth=%0d err=%b, required all 0",
               bus.irq_o, bus.irq_id_o, bus.claim_o, bus.level_o, bus.depth_o, bus.err_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive(1, 5, 3, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 6'd5) begin
      n_fail++;
      $display("FAIL basic_offer: irq=%b id=%0d, required irq=1 id=5", bus.irq_o, bus.irq_id_o);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    n_tests++;
    if (bus.claim_o !== 1'b1 || bus.claim_id_o !== 6'd5 || bus.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_claim: claim=%b id=%0d irq=%b, required claim=1 id=5 irq=0",
               bus.claim_o, bus.claim_id_o, bus.irq_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.claim_o !== 1'b0 || bus.level_o !== 5'd3 || bus.depth_o !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_running: claim=%b level=%0d depth=%0d, required claim=0 level=3 depth=1",
               bus.claim_o, bus.level_o, bus.depth_o);
    end
  endtask

  // Expects level 3 nest 1 running (left by test_basic); leaves the stack empty.
  task automatic test_nest_preempt();
    bit seen = 0;
    drive(1, 9, 2, 1, 0, 0, 0);
    repeat (3) begin
      tick();
      if (bus.irq_o) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL nest_lower_blocked: irq seen=1, required 0");
    end
    drive(1, 10, 7, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 6'd10) begin
      n_fail++;
      $display("FAIL nest_higher_offer: irq=%b id=%0d, required irq=1 id=10", bus.irq_o, bus.irq_id_o);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.level_o !== 5'd7 || bus.depth_o !== 3'd2) begin
      n_fail++;
      $display("FAIL nest_depth2: level=%0d depth=%0d, required level=7 depth=2", bus.level_o, bus.depth_o);
    end
    pop_once();
    pop_once();
    n_tests++;
    if (bus.level_o !== 5'd0 || bus.depth_o !== 3'd0) begin
      n_fail++;
      $display("FAIL nest_unwind: level=%0d depth=%0d, required 0 0", bus.level_o, bus.depth_o);
    end
  endtask

  task automatic test_no_nest();
    bit seen = 0;
    take_irq(2, 3, 0);
    drive(1, 20, 31, 1, 0, 0, 0);
    repeat (5) begin
      tick();
      if (bus.irq_o) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL no_nest_blocked: irq seen=1, required 0");
    end
    drive(1, 20, 31, 1, 0, 0, 1);
    tick();
    n_tests++;
    if (bus.level_o !== 5'd0 || bus.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_nest_exit: level=%0d irq=%b, required level=0 irq=0", bus.level_o, bus.irq_o);
    end
    drive(1, 20, 31, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 6'd20) begin
      n_fail++;
      $display("FAIL no_nest_reoffer: irq=%b id=%0d, required irq=1 id=20", bus.irq_o, bus.irq_id_o);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.level_o !== 5'd31 || bus.depth_o !== 3'd1) begin
      n_fail++;
      $display("FAIL no_nest_level31: level=%0d depth=%0d, required 31 1", bus.level_o, bus.depth_o);
    end
    pop_once();
  endtask

  task automatic test_withdraw();
    drive(1, 5, 3, 1, 0, 0, 0);
    tick();
    drive(1, 8, 6, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_bubble: irq=%b, required 0", bus.irq_o);
    end
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 6'd8) begin
      n_fail++;
      $display("FAIL withdraw_reoffer: irq=%b id=%0d, required irq=1 id=8", bus.irq_o, bus.irq_id_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_invalid: irq=%b, required 0", bus.irq_o);
    end
    drive(1, 5, 3, 1, 0, 0, 0);
    tick();
    drive(1, 8, 6, 1, 0, 1, 0);
    tick();
    n_tests++;
    if (bus.claim_o !== 1'b1 || bus.claim_id_o !== 6'd5) begin
      n_fail++;
      $display("FAIL ack_wins: claim=%b id=%0d, required claim=1 id=5", bus.claim_o, bus.claim_id_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.level_o !== 5'd3 || bus.depth_o !== 3'd1 || bus.claim_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_wins_level: level=%0d depth=%0d claim=%b, required 3 1 0",
               bus.level_o, bus.depth_o, bus.claim_o);
    end
    pop_once();
  endtask

  task automatic test_full();
    bit seen = 0;
    take_irq(1, 2, 1);
    take_irq(2, 4, 1);
    take_irq(3, 6, 1);
    take_irq(4, 8, 1);
    n_tests++;
    if (bus.depth_o !== 3'd4 || bus.level_o !== 5'd8) begin
      n_fail++;
      $display("FAIL full_depth: depth=%0d level=%0d, required 4 8", bus.depth_o, bus.level_o);
    end
    drive(1, 40, 20, 1, 0, 0, 0);
    repeat (4) begin
      tick();
      if (bus.irq_o) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL full_blocked: irq seen=1, required 0");
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    n_tests++;
    if (bus.depth_o !== 3'd0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_unwind: depth=%0d err=%b, required 0 0", bus.depth_o, bus.err_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    n_tests++;
    if (bus.err_o !== 1'b1 || bus.depth_o !== 3'd0) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b depth=%0d, required err=1 depth=0", bus.err_o, bus.depth_o);
    end
    do_reset();
    n_tests++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: err=%b, required 0", bus.err_o);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    take_irq(1, 2, 1);
    take_irq(2, 5, 1);
    drive(1, 30, 9, 1, 1, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_heti_o !== 1'b1 || bus.irq_id_o !== 6'd30) begin
      n_fail++;
      $display("FAIL b2b_offer: irq=%b heti=%b id=%0d, required 1 1 30",
               bus.irq_o, bus.irq_heti_o, bus.irq_id_o);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_tests++;
    if (bus.depth_o !== 3'd2 || bus.level_o !== 5'd9) begin
      n_fail++;
      $display("FAIL b2b_pop_push: depth=%0d level=%0d, required 2 9", bus.depth_o, bus.level_o);
    end
    drive(1, 3, 12, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 6'd3) begin
      n_fail++;
      $display("FAIL b2b_offer2: irq=%b id=%0d, required 1 3", bus.irq_o, bus.irq_id_o);
    end
    drive(1, 3, 12, 1, 0, 1, 0);
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({bus.irq_o, bus.irq_id_o, bus.irq_heti_o, bus.claim_o, bus.claim_id_o,
         bus.level_o, bus.depth_o, bus.err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_offer: irq=%b claim=%b level=%0d depth=%0d, required all 0",
               bus.irq_o, bus.claim_o, bus.level_o, bus.depth_o);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    repeat (3) begin
      tick();
      if (bus.claim_o) seen = 1;
    end
    n_tests++;
    if (seen || bus.depth_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_claim: claim seen=%b depth=%0d, required 0 0", seen, bus.depth_o);
    end
  endtask

  function automatic bit m_elig(int lvl);
    if (stk.size() == 0) return lvl > 0;
    return (stk.size() < Depth) && stk[$].nest && (lvl > stk[$].level);
  endfunction

  task automatic test_random();
    int  mst, nxt, l_id, l_lvl, id, lvl, e_lvl, mmax;
    bit  l_nest, l_heti, merr, v, nest, heti, ack, ex;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      stk.delete();
      mst = 0; merr = 0; l_id = 0; l_lvl = 0; l_nest = 0; l_heti = 0; mmax = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        v    = ($urandom_range(0, 9) < 7);
        id   = $urandom_range(0, Lines - 1);
        lvl  = $urandom_range(0, Prios - 1);
        nest = ($urandom_range(0, 9) < 7);
        heti = $urandom_range(0, 1);
        ack  = ($urandom_range(0, 2) == 0);
        ex   = ($urandom_range(0, 11) == 0);
        drive(v, id, lvl, nest, heti, ack, ex);
        if (stk.size() > mmax) mmax = stk.size();
        nxt = mst;
        case (mst)
          0: if (v && m_elig(lvl)) begin
               l_id = id; l_lvl = lvl; l_nest = nest; l_heti = heti; nxt = 1;
             end
          1: if (ack) nxt = 2;
             else if (!v || lvl > l_lvl || !m_elig(l_lvl)) nxt = 0;
          default: nxt = 0;
        endcase
        if (ex) begin
          if (stk.size() == 0) merr = 1;
          else void'(stk.pop_back());
        end
        if (mst == 2) stk.push_back('{level: l_lvl, nest: l_nest});
        mst = nxt;
        tick();
        e_lvl = (stk.size() == 0) ? 0 : stk[$].level;
        n_tests++;
        if (bus.irq_o !== (mst == 1) || bus.irq_id_o !== ((mst == 1) ? 6'(l_id) : 6'd0) ||
            bus.irq_heti_o !== ((mst == 1) && l_heti) || bus.claim_o !== (mst == 2) ||
            bus.claim_id_o !== ((mst == 2) ? 6'(l_id) : 6'd0) || bus.level_o !== 5'(e_lvl) ||
            bus.depth_o !== 3'(stk.size()) || bus.err_o !== merr) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: irq=%b id=%0d claim=%b cid=%0d level=%0d depth=%0d err=%b, required irq=%b id=%0d claim=%b level=%0d depth=%0d err=%b",
                   blk, cyc, bus.irq_o, bus.irq_id_o, bus.claim_o, bus.claim_id_o, bus.level_o,
                   bus.depth_o, bus.err_o, (mst == 1), l_id, (mst == 2), e_lvl, stk.size(), merr);
        end
`ifdef IRQ_NEST_WATERMARK_EN
        n_tests++;
        if (depth_max !== 3'(mmax)) begin
          n_fail++;
          $display("FAIL watermark[%0d.%0d]: depth_max=%0d, required %0d", blk, cyc, depth_max, mmax);
        end
`endif
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_nest_preempt();
    test_no_nest();
    test_withdraw();
    test_full();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
